axi_regfile_v2: RTL and testbench
=================================

Name: axi_regfile_v2

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed 16 x 32-bit regfile that sits on the PS M00_AXI port in top.
- Adds configurable register count, per-register reset values, read-only and self-clearing pulse registers, byte strobes, SLVERR decode, and independently buffered AW/W channels.
- Fabric logic sees a packed slv_reg output array and drives a packed slv_read input array.

Parameters:
- NREGS, 16: number of 32-bit registers, 2..256.
- C_S_AXI_ADDR_WIDTH, 10: decoded address bits; must satisfy 2^C_S_AXI_ADDR_WIDTH >= 4*NREGS.
- RESET_VAL, '0: NREGS*32-bit packed reset value; register i occupies [32*i +: 32].
- RO_MASK, '0: NREGS-bit; bit i set = register i is read-only; writes are ignored with OKAY response.
- PULSE_MASK, '0: NREGS-bit; bit i set = register i holds a written value for exactly one cycle, then returns to 0.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  40  write address; only [C_S_AXI_ADDR_WIDTH-1:0] decoded.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  40  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake.
- slv_reg  out  NREGS*32  register contents to fabric.
- slv_read  in  NREGS*32  readback values from fabric.
- wr_stb  out  NREGS  per-register write strobe (optional feature).
- rd_stb  out  NREGS  per-register read strobe (optional feature).

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. While S_AXI_ARESET is high:
  - slv_reg = RESET_VAL.
  - All VALID/READY outputs, RDATA, RESP, wr_stb and rd_stb are 0.
  - Any in-flight transaction is discarded.
  - READY outputs rise on the first cycle after reset deasserts.
- Decode:
  - idx = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] and bits above C_S_AXI_ADDR_WIDTH are ignored.
  - idx >= NREGS is out of range.
- Write path: AW and W are captured into independent one-entry holding buffers, in either order or the same cycle.
  - AWREADY = AW buffer empty. WREADY = W buffer empty.
  - Commit edge: the first edge at which both buffers are full and BVALID is 0.
  - At commit, for each lane b with WSTRB[b]=1, slv_reg[idx][8b+:8] <= WDATA[8b+:8], unless idx is out of range or RO_MASK[idx]=1.
  - Also at commit: both buffers empty, BVALID <= 1, BRESP <= SLVERR if out of range, else OKAY.
  - Latency: AW+W handshake at edge E -> slv_reg updated and BVALID=1 after edge E+1.
  - BVALID/BRESP hold until the BREADY handshake. New AW/W may be buffered while B is pending; the next commit waits for the B handshake.
  - PULSE_MASK[i]=1: slv_reg[i] shows the written value for exactly one cycle, then is 0. WSTRB=0 still produces a one-cycle pulse of 0, i.e. no visible change.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake at edge E: RDATA <= slv_read[idx] sampled at E; RVALID <= 1 after E.
  - Out of range: RDATA = 0, RRESP = SLVERR.
  - RDATA/RRESP stay stable until the RREADY handshake. Back-to-back reads sustain one read per 2 cycles.
- Read and write to the same index in the same cycle: the read returns slv_read sampled at the AR edge, so a write committing at that edge is not visible.
- Read and write channels are fully independent; neither stalls the other.

Optional Feature:
- Macro: AXI_REGFILE_STROBE_EN.
- Defined:
  - wr_stb[idx] pulses high for one cycle, coincident with the slv_reg update, on in-range non-RO commits.
  - rd_stb[idx] pulses high for one cycle after an in-range AR handshake edge. Intended for FIFO pops and clear-on-read in fabric.
- Undefined: wr_stb and rd_stb are tied to 0 and the strobe logic is not generated. All other behaviour is identical.

Test Plan:
- Reset release with RESET_VAL[reg3]=32'h0000_00A5 -> slv_reg[3]=32'hA5, all READY=1 on the first post-reset cycle, BVALID=RVALID=0.
- AW (addr 0x08) two cycles before W (data 32'h1234_5678, strb 4'b0101) -> AWREADY low while holding, slv_reg[2]=32'h0034_0078 from 0, BVALID one cycle after W, BRESP=OKAY.
- Write 32'hFFFF_FFFF to RO_MASK register 1 with slv_read[1]=32'h7654_3210 -> slv_reg[1] unchanged, BRESP=OKAY, read returns 32'h7654_3210.
- Write 32'h1 to PULSE_MASK register 5 -> slv_reg[5]=1 for exactly one cycle then 0; with AXI_REGFILE_STROBE_EN, wr_stb[5] pulses in the same cycle.
- NREGS=16: write then read at addr 0x40 -> BRESP=SLVERR, no slv_reg change, RDATA=0, RRESP=SLVERR.
- Hold BREADY=0 for 10 cycles and issue a second AW+W -> second pair buffered (AWREADY=WREADY=0 afterwards), commit one edge after the first B handshake; reset asserted mid-sequence clears BVALID and the buffers, and slv_reg returns to RESET_VAL.

Source files
------------

// File: rtl/axi_regfile_v2.sv
// AXI4-Lite slave register file: NREGS x 32-bit, byte strobes, RO/pulse registers, SLVERR decode.
// Define AXI_REGFILE_STROBE_EN to generate the per-register wr_stb/rd_stb outputs.
module axi_regfile_v2 #(
  parameter int                  NREGS              = 16,
  parameter int                  C_S_AXI_ADDR_WIDTH = 10,
  parameter logic [NREGS*32-1:0] RESET_VAL          = '0,
  parameter logic [NREGS-1:0]    RO_MASK            = '0,
  parameter logic [NREGS-1:0]    PULSE_MASK         = '0
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic [39:0]           S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [39:0]           S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [NREGS*32-1:0]   slv_reg,
  input  logic [NREGS*32-1:0]   slv_read,
  output logic [NREGS-1:0]      wr_stb,
  output logic [NREGS-1:0]      rd_stb
);
  localparam int         IDXW        = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return (32'(idx) < 32'(NREGS));
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (data & mask);
  endfunction

  function automatic logic [31:0] read_mux(input logic [IDXW-1:0] idx,
                                           input logic [NREGS*32-1:0] vec);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < NREGS; i++) begin
      r = r | ((idx == IDXW'(i)) ? vec[32*i +: 32] : 32'h0000_0000);
    end
    return r;
  endfunction

  logic                aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [IDXW-1:0]     aw_idx_q, aw_idx_d;
  logic [31:0]         w_data_q, w_data_d;
  logic [3:0]          w_strb_q, w_strb_d;
  logic                awready_q, wready_q, arready_q;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NREGS*32-1:0] slv_reg_q, slv_reg_d;
  logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [IDXW-1:0]     ar_idx_s;
  logic                unused_ok;

  assign aw_hs_s  = S_AXI_AWVALID & awready_q;
  assign w_hs_s   = S_AXI_WVALID & wready_q;
  assign ar_hs_s  = S_AXI_ARVALID & arready_q;
  assign commit_s = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx_s = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[39:C_S_AXI_ADDR_WIDTH],
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[39:C_S_AXI_ADDR_WIDTH], S_AXI_ARADDR[1:0]};

  // AW/W holding buffers and write response; a commit needs both buffers and a free B slot
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs_s) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end else if (commit_s) begin
      aw_full_d = 1'b0;
    end else begin
      aw_full_d = aw_full_q;
    end
    if (w_hs_s) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end else if (commit_s) begin
      w_full_d = 1'b0;
    end else begin
      w_full_d = w_full_q;
    end
    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q & S_AXI_BREADY) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // Register array next state: pulse registers fall back to zero unless written this cycle
  always_comb begin
    slv_reg_d = slv_reg_q;
    for (int i = 0; i < NREGS; i++) begin
      if (commit_s && !RO_MASK[i] && (aw_idx_q == IDXW'(i))) begin
        slv_reg_d[32*i +: 32] = merge_bytes(PULSE_MASK[i] ? 32'h0000_0000 : slv_reg_q[32*i +: 32],
                                            w_data_q, w_strb_q);
      end else if (PULSE_MASK[i]) begin
        slv_reg_d[32*i +: 32] = 32'h0000_0000;
      end else begin
        slv_reg_d[32*i +: 32] = slv_reg_q[32*i +: 32];
      end
    end
  end

  // Read channel: one-deep response register, fabric value sampled at the AR edge
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = read_mux(ar_idx_s, slv_read);
      rresp_d  = in_range(ar_idx_s) ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q & S_AXI_RREADY) begin
      rvalid_d = 1'b0;
      rdata_d  = 32'h0000_0000;
      rresp_d  = RESP_OKAY;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers; READY flags are registered so they stay low throughout reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= {IDXW{1'b0}};
      w_full_q  <= 1'b0;
      w_data_q  <= 32'h0000_0000;
      w_strb_q  <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      rresp_q   <= RESP_OKAY;
      slv_reg_q <= RESET_VAL;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      arready_q <= ~rvalid_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      slv_reg_q <= slv_reg_d;
    end
  end

`ifdef AXI_REGFILE_STROBE_EN
  logic [NREGS-1:0] wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;

  // One-cycle strobes aligned with the register update / read response
  always_comb begin
    wr_stb_d = {NREGS{1'b0}};
    rd_stb_d = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      wr_stb_d[i] = commit_s & ~RO_MASK[i] & (aw_idx_q == IDXW'(i));
      rd_stb_d[i] = ar_hs_s & (ar_idx_s == IDXW'(i));
    end
  end

  // Strobe registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_stb_q <= {NREGS{1'b0}};
      rd_stb_q <= {NREGS{1'b0}};
    end else begin
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
    end
  end

  assign wr_stb = wr_stb_q;
  assign rd_stb = rd_stb_q;
`else
  assign wr_stb = {NREGS{1'b0}};
  assign rd_stb = {NREGS{1'b0}};
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign slv_reg       = slv_reg_q;

endmodule

// File: tb/tb_axi_regfile_v2.sv
// Scoreboard bench for axi_regfile_v2: B/R responses are queued at issue and checked by a monitor.
module tb_axi_regfile_v2;
  localparam int NREGS = 16;
  localparam logic [511:0] RV = {{12{32'h0000_0000}}, 32'h0000_00A5, {3{32'h0000_0000}}};
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic S_AXI_ARESET;
  logic [39:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [NREGS*32-1:0] slv_reg, slv_read;
  logic [NREGS-1:0] wr_stb, rd_stb;

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0]  bq[$];
  logic [31:0] rdq[$];
  logic [1:0]  rrq[$];
  logic [511:0] exp_reg;
  logic [15:0] exp_wstb;
  logic [1:0]  b_exp, r_exp_r;
  logic [31:0] r_exp_d;

  always #5 clk = ~clk;

  axi_regfile_v2 #(
    .NREGS(NREGS), .C_S_AXI_ADDR_WIDTH(10), .RESET_VAL(RV),
    .RO_MASK(16'h0002), .PULSE_MASK(16'h0020)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .slv_reg(slv_reg), .slv_read(slv_read), .wr_stb(wr_stb), .rd_stb(rd_stb)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] r);
    bit aw, w;
    int t;
    bq.push_back(r);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && t < 40) begin
      @(negedge clk);
      aw = S_AXI_AWVALID && S_AXI_AWREADY;
      w  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk);
      #1;
      if (aw) S_AXI_AWVALID = 1'b0;
      if (w) S_AXI_WVALID = 1'b0;
      t++;
    end
    if (S_AXI_AWVALID || S_AXI_WVALID) begin
      n_checks++; n_fail++;
      $display("FAIL write_handshake: addr %0h not accepted within %0d cycles", a, t);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
  endtask

  task automatic do_read(input logic [39:0] a, input logic [31:0] d, input logic [1:0] r);
    bit ar;
    int t;
    rdq.push_back(d);
    rrq.push_back(r);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (S_AXI_ARVALID && t < 40) begin
      @(negedge clk);
      ar = S_AXI_ARREADY;
      @(posedge clk);
      #1;
      if (ar) S_AXI_ARVALID = 1'b0;
      t++;
    end
    if (S_AXI_ARVALID) begin
      n_checks++; n_fail++;
      $display("FAIL read_handshake: addr %0h not accepted within %0d cycles", a, t);
      S_AXI_ARVALID = 1'b0;
    end
  endtask

  // Response monitor: checks each B/R beat on the cycle its handshake completes
  always @(negedge clk) begin
    if (!S_AXI_ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected: got bresp %0h expected no response", S_AXI_BRESP);
      end else begin
        b_exp = bq.pop_front();
        chk("bresp", S_AXI_BRESP, b_exp);
      end
    end
    if (!S_AXI_ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
      if (rdq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL r_unexpected: got rdata %0h expected no response", S_AXI_RDATA);
      end else begin
        r_exp_d = rdq.pop_front();
        r_exp_r = rrq.pop_front();
        chk("rdata", S_AXI_RDATA, r_exp_d);
        chk("rresp", S_AXI_RRESP, r_exp_r);
      end
    end
  end

  initial begin
    int t;
    S_AXI_ARESET = 1'b1;
    S_AXI_AWADDR = 40'h0; S_AXI_ARADDR = 40'h0; S_AXI_AWPROT = 3'h0; S_AXI_ARPROT = 3'h0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    for (int i = 0; i < NREGS; i++) slv_read[32*i +: 32] = 32'hA000_0000 | 32'(i);
    slv_read[63:32] = 32'h7654_3210;
`ifdef AXI_REGFILE_STROBE_EN
    exp_wstb = 16'h0020;
`else
    exp_wstb = 16'h0000;
`endif

    repeat (3) tick();
    chk("in_reset_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("in_reset_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("in_reset_slv_reg", slv_reg, RV);
    S_AXI_ARESET = 1'b0;
    tick();
    chk("post_reset_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    chk("post_reset_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("post_reset_reg3", slv_reg[127:96], 32'h0000_00A5);
    exp_reg = RV;

    // AW two cycles ahead of W
    bq.push_back(OKAY);
    S_AXI_AWADDR = 40'h08; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("aw_hold_ready", S_AXI_AWREADY, 1'b0);
    tick();
    chk("aw_hold_ready2", S_AXI_AWREADY, 1'b0);
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    chk("split_bvalid_early", S_AXI_BVALID, 1'b0);
    chk("split_reg2_early", slv_reg[95:64], 32'h0);
    tick();
    chk("split_reg2", slv_reg[95:64], 32'h0034_0078);
    chk("split_bvalid", S_AXI_BVALID, 1'b1);
    exp_reg[95:64] = 32'h0034_0078;
    tick();

    // read-only register
    do_write(40'h04, 32'hFFFF_FFFF, 4'hF, OKAY);
    tick(); tick();
    chk("ro_unchanged", slv_reg, exp_reg);
    do_read(40'h04, 32'h7654_3210, OKAY);

    // pulse register
    do_write(40'h14, 32'h0000_0001, 4'hF, OKAY);
    tick();
    chk("pulse_high", slv_reg[191:160], 32'h1);
    chk("pulse_wr_stb", wr_stb, exp_wstb);
    tick();
    chk("pulse_low", slv_reg[191:160], 32'h0);
    chk("pulse_wr_stb_low", wr_stb, 16'h0);

    // out of range, address aliasing, last register
    do_write(40'h40, 32'hDEAD_BEEF, 4'hF, SLVERR);
    tick(); tick();
    chk("oor_no_change", slv_reg, exp_reg);
    do_read(40'h40, 32'h0, SLVERR);
    do_write(40'h80_0000_0018, 32'hCAFE_F00D, 4'b1100, OKAY);
    tick(); tick();
    exp_reg[223:192] = 32'hCAFE_0000;
    chk("upper_addr_ignored", slv_reg, exp_reg);
    do_read(40'h40B, 32'hA000_0002, OKAY);
    do_read(40'h3C, 32'hA000_000F, OKAY);
    do_write(40'h3C, 32'h5A5A_5A5A, 4'hF, OKAY);
    tick(); tick();
    exp_reg[511:480] = 32'h5A5A_5A5A;
    chk("last_reg", slv_reg, exp_reg);

    // B backpressure with a second pair buffered
    S_AXI_BREADY = 1'b0;
    do_write(40'h1C, 32'h1111_1111, 4'hF, OKAY);
    do_write(40'h20, 32'h2222_2222, 4'hF, OKAY);
    exp_reg[255:224] = 32'h1111_1111;
    chk("bp_buffered_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    repeat (10) tick();
    chk("bp_bvalid_held", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, OKAY});
    chk("bp_regs", slv_reg, exp_reg);
    S_AXI_BREADY = 1'b1;
    tick();
    chk("bp_after_hs_bvalid", S_AXI_BVALID, 1'b0);
    chk("bp_after_hs_reg8", slv_reg[287:256], 32'h0);
    tick();
    chk("bp_second_commit", slv_reg[287:256], 32'h2222_2222);
    chk("bp_second_bvalid", S_AXI_BVALID, 1'b1);
    tick();

    // reset in the middle of a pending response and a buffered pair
    S_AXI_BREADY = 1'b0;
    do_write(40'h24, 32'h3333_3333, 4'hF, OKAY);
    do_write(40'h28, 32'h4444_4444, 4'hF, OKAY);
    chk("mid_reg9", slv_reg[319:288], 32'h3333_3333);
    S_AXI_ARESET = 1'b1;
    bq.delete();
    tick(); tick();
    chk("mid_reset_bvalid", S_AXI_BVALID, 1'b0);
    chk("mid_reset_awready", S_AXI_AWREADY, 1'b0);
    chk("mid_reset_regs", slv_reg, RV);
    S_AXI_ARESET = 1'b0;
    S_AXI_BREADY = 1'b1;
    tick();
    chk("mid_release_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    repeat (3) tick();
    chk("mid_discarded_bvalid", S_AXI_BVALID, 1'b0);
    chk("mid_discarded_regs", slv_reg, RV);

    t = 0;
    while ((bq.size() != 0 || rdq.size() != 0) && t < 50) begin
      tick();
      t++;
    end
    if (bq.size() != 0 || rdq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d B and %0d R responses outstanding, 0 expected",
               bq.size(), rdq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
